// File: rtl/btn_pkg.sv
// Shared constants and helpers for the button bank.
//
// Register offsets are relative to NUM_BTN: addresses 0..NUM_BTN-1 are the
// per-channel clear-on-read pending bits, followed by the level vector, the
// pending vector and the irq mask.
package btn_pkg;

    localparam int unsigned LEVEL_OFS = 0;
    localparam int unsigned PEND_OFS  = 1;
    localparam int unsigned MASK_OFS  = 2;

    // Width of a debounce counter that must hold values 0..cycles-1.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser, polarity fix-up and debounce counter.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous active-high reset
//   pin    - raw asynchronous button pin
//   level  - debounced level, 1 = pressed
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level
);

    localparam int unsigned      CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    // Raw pin value of a released button; the synchroniser resets to it so
    // that reset release never looks like an edge.
    localparam logic [1:0]       SYNC_RELEASED = {2{ACTIVE_LOW}};

    logic [1:0]    sync_q, sync_d;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pressed;

    assign pressed = sync_q[1] ^ ACTIVE_LOW;

    always_comb begin
        sync_d  = {sync_q[0], pin};
        level_d = level_q;
        cnt_d   = cnt_q;
        if (pressed == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // DEBOUNCE_CYCLES consecutive disagreeing samples: accept the new level.
            level_d = pressed;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= SYNC_RELEASED;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/btn_bank.sv
// Bank of debounced push buttons with sticky press flags and a small register map.
//
// Optional feature: define BTN_IRQ_EN to add the irq mask register, W1C
// clearing of the pending vector and the interrupt output. Without it writes
// are ignored, the mask reads as 0 and irq is tied low.
//
// Ports:
//   clk, reset    - rising-edge clock, synchronous active-high reset
//   btn           - raw button pins, one per channel
//   read_enable   - read strobe; data_out is valid the following cycle
//   write_enable  - write strobe
//   address       - register address
//   data_in       - write data
//   data_out      - registered read data (0 when no read was issued)
//   irq           - registered interrupt request
module btn_bank
    import btn_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 8,
    parameter int unsigned NUM_BTN         = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_BTN-1:0]    btn,
    input  logic                  read_enable,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           data_in,
    output logic [31:0]           data_out,
    output logic                  irq
);

    localparam int unsigned ADDR_LEVEL = NUM_BTN + LEVEL_OFS;
    localparam int unsigned ADDR_PEND  = NUM_BTN + PEND_OFS;
    localparam int unsigned ADDR_MASK  = NUM_BTN + MASK_OFS;

    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] level_prev_q, level_prev_d;
    logic [NUM_BTN-1:0] pend_q, pend_d;
    logic [NUM_BTN-1:0] rise, cor_clr, w1c_clr;
    logic [31:0]        addr_ext, rdata;
    logic [31:0]        data_out_q, data_out_d;
    logic               unused_bits;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_deb (
            .clk   (clk),
            .reset (reset),
            .pin   (btn[g]),
            .level (level[g])
        );
    end

    assign addr_ext = 32'(address);

`ifdef BTN_IRQ_EN
    logic [NUM_BTN-1:0] mask_q, mask_d;
    logic               irq_q, irq_d;

    always_comb begin
        mask_d  = mask_q;
        w1c_clr = '0;
        if (write_enable && (addr_ext == ADDR_MASK)) begin
            mask_d = data_in[NUM_BTN-1:0];
        end
        if (write_enable && (addr_ext == ADDR_PEND)) begin
            w1c_clr = data_in[NUM_BTN-1:0];
        end
        irq_d = |(pend_q & mask_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end

    assign irq         = irq_q;
    assign unused_bits = ^data_in[31:NUM_BTN];
`else
    assign w1c_clr     = '0;
    assign irq         = 1'b0;
    assign unused_bits = ^{write_enable, data_in};
`endif

    // Read decode; reads always see the pending state from before this edge.
    always_comb begin
        rdata   = '0;
        cor_clr = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (addr_ext == 32'(i)) begin
                rdata      = {31'b0, pend_q[i]};
                cor_clr[i] = read_enable;
            end
        end
        if (addr_ext == ADDR_LEVEL) begin
            rdata = 32'(level);
        end
        if (addr_ext == ADDR_PEND) begin
            rdata = 32'(pend_q);
        end
`ifdef BTN_IRQ_EN
        if (addr_ext == ADDR_MASK) begin
            rdata = 32'(mask_q);
        end
`endif
    end

    always_comb begin
        level_prev_d = level;
        rise         = level & ~level_prev_q;
        // A press arriving on the same edge as a clear wins, so it is not lost.
        pend_d       = (pend_q & ~(cor_clr | w1c_clr)) | rise;
        data_out_d   = read_enable ? rdata : 32'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_prev_q <= '0;
            pend_q       <= '0;
            data_out_q   <= '0;
        end else begin
            level_prev_q <= level_prev_d;
            pend_q       <= pend_d;
            data_out_q   <= data_out_d;
        end
    end

    assign data_out = data_out_q;

endmodule

// File: doc/btn_bank.md
BTN_BANK -- requirements
Module: btn_bank

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, meaning read/write address width.
REQ-002 SHALL have parameter NUM_BTN, default 4, range 1..16, meaning number of button channels.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 16, range 2..65535, meaning stable cycles required before the debounced level changes.
REQ-004 SHALL have parameter ACTIVE_LOW, default 1, meaning that pin value 0 = pressed when 1, pin value 1 = pressed when 0.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have port btn, input, NUM_BTN bits, raw asynchronous button pins.
REQ-008 SHALL have port read_enable, input, 1 bit, read strobe.
REQ-009 SHALL have port write_enable, input, 1 bit, write strobe.
REQ-010 SHALL have port address, input, ADDR_WIDTH bits, register address.
REQ-011 SHALL have port data_in, input, 32 bits, write data.
REQ-012 SHALL have port data_out, output, 32 bits, registered read data.
REQ-013 SHALL have port irq, output, 1 bit, registered interrupt request.

Function
REQ-014 SHALL pass each pin through a 2-flop synchroniser, then apply ACTIVE_LOW inversion, giving pressed=1.
REQ-015 SHALL keep one debounce counter per channel: cleared when the synced value equals the debounced level, else incremented; the level takes the synced value and the counter clears when the count reaches DEBOUNCE_CYCLES-1.
REQ-016 SHALL therefore change the debounced level exactly 2+DEBOUNCE_CYCLES cycles after a clean pin edge; any glitch shorter than DEBOUNCE_CYCLES cycles SHALL NOT change the level.
REQ-017 SHALL set sticky pending[i] on each debounced 0->1 transition of channel i; releases set nothing.
REQ-018 SHALL decode the address map as follows:
- 0..NUM_BTN-1: {31'b0, pending[i]}, clear-on-read.
- NUM_BTN: live debounced level vector.
- NUM_BTN+1: pending vector, no clear.
- NUM_BTN+2: irq mask.
- any other address: 0.
- All vector reads are zero-extended.
REQ-019 SHALL register data_out one cycle after read_enable, and SHALL drive data_out = 0 in any cycle following read_enable = 0.
REQ-020 SHALL clear pending[i] on a clear-on-read in the same edge that loads data_out.
REQ-021 SHALL, when a press event and a clear on the same channel coincide, read the old value and leave pending[i] = 1, so no press is lost.
REQ-022 SHALL give read priority when read_enable and write_enable are both high: the read executes and the write executes too, except that a clear-on-read and a W1C to the same bit both clear it.

Reset
REQ-023 SHALL, on reset, set data_out, pending, mask, irq, debounced levels and counters to 0, and load the synchronisers with the released value.
REQ-024 SHALL, on reset asserted mid-debounce, discard the count, and SHALL generate no press event from reset release with buttons idle.

Configuration
REQ-025 SHALL, with BTN_IRQ_EN defined:
- write to NUM_BTN+2 loads mask <= data_in[NUM_BTN-1:0].
- write to NUM_BTN+1 clears pending bits where data_in = 1 (W1C).
- irq <= |(pending & mask), one cycle after pending/mask change.
REQ-026 SHALL, without BTN_IRQ_EN: ignore writes, tie irq to 0, read address NUM_BTN+2 as 0, and omit the mask register.

Structure
REQ-027 SHALL place address offset constants and a counter-width function ($clog2(DEBOUNCE_CYCLES)) in shared package btn_pkg.
REQ-028 SHALL implement the per-channel synchroniser and debounce counter in sub-module btn_debounce, instantiated NUM_BTN times via generate; btn_bank SHALL hold the edge detect, pending, registers and decode.

Verification (NUM_BTN=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1)
REQ-029 SHALL check: btn[0] held 0 from cycle 10 -> level[0]=1 at cycle 16; read addr 0 -> data_out=1 next cycle; re-read -> 0.
REQ-030 SHALL check: btn[1] low for 3 cycles, then high -> level and pending stay 0; read addr 3 -> 0.
REQ-031 SHALL check: press event on ch0 in the same cycle as a read of addr 0 with pending=1 -> data_out=1 and pending[0] still 1.
REQ-032 SHALL check, with BTN_IRQ_EN: write mask=2'b10, press ch1 -> irq=1 one cycle after pending[1]; W1C 2'b10 to addr 3 -> irq=0 one cycle later; press ch0 -> irq stays 0.
REQ-033 SHALL check: reset asserted at debounce count 2 -> count discarded, level 0, no pending; read addr 7 -> 0; with read_enable low -> data_out=0.
